digitube_scanner: RTL

Drives a 4-digit multiplexed 7-segment display from static per-digit data. It is the transmit side of the scanned digit-tube bus: it takes four hex nibbles plus decimal-point and blank masks and time-multiplexes them onto one 12-bit `{AN3..AN0, DP, CG..CA}` word. It sits between the CPU's display register and the board's scanned tube pins, or the scan-to-static adapter on DE2. Each frame works from one snapshot of the inputs, so the display never tears, and a blank gap between digits suppresses ghosting.

---
 rtl/digitube_pkg.sv | 25 ++
 rtl/hex_to_seg7.sv | 11 +
 rtl/digitube_scanner.sv | 123 ++++++++++++
 3 files changed

// File: rtl/digitube_pkg.sv
// rtl/digitube_pkg.sv - shared constants, segment table and state encoding for digit-tube scanning
package digitube_pkg;

  localparam logic [11:0] OFF = 12'h0FF;

  localparam int AN_MSB  = 11;
  localparam int AN_LSB  = 8;
  localparam int DP_BIT  = 7;
  localparam int SEG_MSB = 6;
  localparam int SEG_LSB = 0;

  // Active-low segments, bit0 = CA ... bit6 = CG
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef enum logic {
    S_SHOW = 1'b0,
    S_GAP  = 1'b1
  } state_t;

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to active-low 7-segment decoder
module hex_to_seg7
  import digitube_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/digitube_scanner.sv
// rtl/digitube_scanner.sv - 4-digit multiplexed 7-segment scanner with per-frame input snapshot
module digitube_scanner
  import digitube_pkg::*;
#(
  parameter int DIV = 50000,
  parameter int GAP = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic [3:0]  blank,
  output logic [11:0] digi_out,
  output logic        frame_done
);

  localparam int MAXC = (DIV > GAP) ? ((DIV > 2) ? DIV : 2) : ((GAP > 2) ? GAP : 2);
  localparam int CW   = $clog2(MAXC);

  state_t          state_q, state_d;
  logic [1:0]      digit_q, digit_d;
  logic [CW-1:0]   count_q, count_d;

  logic [15:0]     value_l;
  logic [3:0]      dp_l, blank_l;

  logic            frame_start, show_last, gap_last;
  logic [15:0]     cur_value;
  logic [3:0]      cur_dp, cur_blank;
  logic [6:0]      seg;
  logic [11:0]     word_d;
  logic            done_d;

  assign frame_start = en && (state_q == S_SHOW) && (digit_q == 2'd0) && (count_q == '0);
  assign show_last   = (count_q == CW'(DIV - 1));
  assign gap_last    = (count_q == CW'(GAP - 1));

  // The first word of a frame is decoded from the inputs being latched on that same edge
  assign cur_value = frame_start ? value : value_l;
  assign cur_dp    = frame_start ? dp    : dp_l;
  assign cur_blank = frame_start ? blank : blank_l;

  hex_to_seg7 u_dec (
    .nibble (cur_value[{digit_q, 2'b00} +: 4]),
    .seg    (seg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_SHOW;
      digit_q <= 2'd0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    count_d = count_q;
    if (!en) begin
      state_d = S_SHOW;
      digit_d = 2'd0;
      count_d = '0;
    end else begin
      case (state_q)
        S_SHOW: begin
          if (show_last) begin
            count_d = '0;
            if (GAP > 0) state_d = S_GAP;
            else         digit_d = digit_q + 2'd1;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
        default: begin
          if (gap_last) begin
            state_d = S_SHOW;
            digit_d = digit_q + 2'd1;
            count_d = '0;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    word_d = OFF;
    if (en && (state_q == S_SHOW) && !cur_blank[digit_q]) begin
      word_d[AN_MSB:AN_LSB]   = 4'b0001 << digit_q;
      word_d[DP_BIT]          = ~cur_dp[digit_q];
      word_d[SEG_MSB:SEG_LSB] = seg;
    end
    done_d = en && (digit_q == 2'd3) &&
             (((state_q == S_GAP) && gap_last) ||
              ((GAP == 0) && (state_q == S_SHOW) && show_last));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_l    <= '0;
      dp_l       <= '0;
      blank_l    <= '0;
      digi_out   <= OFF;
      frame_done <= 1'b0;
    end else begin
      if (frame_start) begin
        value_l <= value;
        dp_l    <= dp;
        blank_l <= blank;
      end
      digi_out   <= word_d;
      frame_done <= done_d;
    end
  end

endmodule
